// File: rtl/burst_err_pkg.sv
// Shared types and constants for the burst error injector: mode/state enums,
// LFSR seed/taps and the LFSR next-state function.
package burst_err_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_BURST  = 2'b01,
    MODE_RANDOM = 2'b10
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUILD = 2'b01,
    ST_HOLD  = 2'b10
  } state_e;

  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1 -> feedback from bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/burst_error_injector_if.sv
// Stream handshake bundle between Hamming encoder, injector and decoder.
interface burst_error_injector_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_err_mask;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_err_mask
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_err_mask
  );
endinterface

// File: rtl/burst_err_lfsr.sv
// 16-bit Fibonacci LFSR (shift left); load has priority over step and a zero
// seed is replaced by the default so the register never locks up.
module burst_err_lfsr
  import burst_err_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] nxt
);

  logic [15:0] state_q, state_d;

  assign nxt = lfsr_next(state_q);

  always_comb begin
    state_d = state_q;
    if (load)      state_d = (seed == 16'h0) ? LFSR_DEFAULT_SEED : seed;
    else if (step) state_d = nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LFSR_DEFAULT_SEED;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/burst_error_injector.sv
// Streaming error injector: PASS / wrap-around BURST / LFSR RANDOM masks on every
// Nth word. RANDOM mode exists only when BURST_ERR_LFSR_EN is defined.
module burst_error_injector
  import burst_err_pkg::*;
#(
  parameter int DATA_W   = 128,
  parameter int POS_W    = $clog2(DATA_W),
  parameter int PERIOD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [1:0]           cfg_mode,
  input  logic [POS_W-1:0]     cfg_start,
  input  logic [POS_W:0]       cfg_len,
  input  logic [POS_W-1:0]     cfg_step,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic [15:0]          cfg_seed,
  burst_error_injector_if.slave bus,
  output logic [15:0]          inj_count
);

  localparam logic [POS_W:0] LEN_MAX = (POS_W+1)'(DATA_W);

  state_e               state_q, state_d;
  logic [1:0]           cfg_mode_q, cfg_mode_d;
  logic [POS_W-1:0]     cfg_start_q, cfg_start_d;
  logic [POS_W:0]       cfg_len_q, cfg_len_d;
  logic [POS_W-1:0]     cfg_step_q, cfg_step_d;
  logic [PERIOD_W-1:0]  cfg_period_q, cfg_period_d;
  logic [PERIOD_W-1:0]  word_cnt_q, word_cnt_d;
  logic [POS_W-1:0]     cur_start_q, cur_start_d;
  logic [DATA_W-1:0]    data_q, data_d;
  logic [DATA_W-1:0]    mask_q, mask_d;
  logic                 inj_q, inj_d;
  mode_e                snap_mode_q, snap_mode_d;
  logic [POS_W-1:0]     snap_start_q, snap_start_d;
  logic [POS_W:0]       snap_len_q, snap_len_d;
  logic [15:0]          inj_count_q, inj_count_d;

  mode_e                acc_mode;
  logic [POS_W:0]       acc_len;
  logic [PERIOD_W-1:0]  eff_period;
  logic                 acc_inject;

  // Mask bit j is set when its distance from start (mod DATA_W) is below len.
  function automatic logic [DATA_W-1:0] burst_mask(input logic [POS_W-1:0] start,
                                                   input logic [POS_W:0]   len);
    logic [DATA_W-1:0] m;
    logic [POS_W-1:0]  off;
    m = '0;
    for (int j = 0; j < DATA_W; j++) begin
      off  = POS_W'(j) - start;
      m[j] = ({1'b0, off} < len);
    end
    return m;
  endfunction

`ifdef BURST_ERR_LFSR_EN
  logic [15:0]    lfsr_nxt;
  logic           lfsr_step;
  logic [POS_W:0] rnd_cnt_q, rnd_cnt_d;
  logic           unused_lfsr_hi;

  burst_err_lfsr u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (cfg_we),
    .seed (cfg_seed),
    .step (lfsr_step),
    .nxt  (lfsr_nxt)
  );

  assign lfsr_step      = (state_q == ST_BUILD) && (snap_mode_q == MODE_RANDOM);
  assign unused_lfsr_hi = ^lfsr_nxt;
`else
  logic unused_seed;
  assign unused_seed = ^cfg_seed;
`endif

  assign bus.in_ready     = (state_q == ST_IDLE);
  assign bus.out_valid    = (state_q == ST_HOLD);
  assign bus.out_data     = data_q ^ mask_q;
  assign bus.out_err_mask = mask_q;
  assign inj_count        = inj_count_q;

  // Decode of the word being accepted, always from the registered (old) config.
  always_comb begin
    case (cfg_mode_q)
      2'b01:   acc_mode = MODE_BURST;
`ifdef BURST_ERR_LFSR_EN
      2'b10:   acc_mode = MODE_RANDOM;
`endif
      default: acc_mode = MODE_PASS;
    endcase
    acc_len    = (cfg_len_q > LEN_MAX) ? LEN_MAX : cfg_len_q;
    eff_period = (cfg_period_q == '0) ? PERIOD_W'(1) : cfg_period_q;
    acc_inject = (word_cnt_q == '0) && (acc_mode != MODE_PASS) && (acc_len != '0);
  end

  always_comb begin
    state_d      = state_q;
    cfg_mode_d   = cfg_mode_q;
    cfg_start_d  = cfg_start_q;
    cfg_len_d    = cfg_len_q;
    cfg_step_d   = cfg_step_q;
    cfg_period_d = cfg_period_q;
    word_cnt_d   = word_cnt_q;
    cur_start_d  = cur_start_q;
    data_d       = data_q;
    mask_d       = mask_q;
    inj_d        = inj_q;
    snap_mode_d  = snap_mode_q;
    snap_start_d = snap_start_q;
    snap_len_d   = snap_len_q;
    inj_count_d  = inj_count_q;
`ifdef BURST_ERR_LFSR_EN
    rnd_cnt_d    = rnd_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          state_d      = ST_BUILD;
          data_d       = bus.in_data;
          mask_d       = '0;
          inj_d        = acc_inject;
          snap_mode_d  = acc_inject ? acc_mode : MODE_PASS;
          snap_start_d = cur_start_q;
          snap_len_d   = acc_len;
          word_cnt_d   = (word_cnt_q == eff_period - PERIOD_W'(1)) ? '0
                                                                 : word_cnt_q + PERIOD_W'(1);
          // Advancing here rather than in BUILD lets a same-edge cfg_we win cleanly.
          if (acc_inject && acc_mode == MODE_BURST) cur_start_d = cur_start_q + cfg_step_q;
`ifdef BURST_ERR_LFSR_EN
          rnd_cnt_d    = acc_len;
`endif
        end
      end
      ST_BUILD: begin
        case (snap_mode_q)
          MODE_BURST: begin
            mask_d  = burst_mask(snap_start_q, snap_len_q);
            state_d = ST_HOLD;
          end
`ifdef BURST_ERR_LFSR_EN
          MODE_RANDOM: begin
            mask_d[lfsr_nxt[POS_W-1:0]] = ~mask_q[lfsr_nxt[POS_W-1:0]];
            rnd_cnt_d = rnd_cnt_q - (POS_W+1)'(1);
            if (rnd_cnt_q == (POS_W+1)'(1)) state_d = ST_HOLD;
          end
`endif
          default: state_d = ST_HOLD;
        endcase
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
          if (inj_q && inj_count_q != 16'hFFFF) inj_count_d = inj_count_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cfg_we) begin
      cfg_mode_d   = cfg_mode;
      cfg_start_d  = cfg_start;
      cfg_len_d    = cfg_len;
      cfg_step_d   = cfg_step;
      cfg_period_d = cfg_period;
      word_cnt_d   = '0;
      cur_start_d  = cfg_start;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cfg_mode_q   <= 2'b00;
      cfg_start_q  <= '0;
      cfg_len_q    <= '0;
      cfg_step_q   <= '0;
      cfg_period_q <= PERIOD_W'(1);
      word_cnt_q   <= '0;
      cur_start_q  <= '0;
      data_q       <= '0;
      mask_q       <= '0;
      inj_q        <= 1'b0;
      snap_mode_q  <= MODE_PASS;
      snap_start_q <= '0;
      snap_len_q   <= '0;
      inj_count_q  <= '0;
`ifdef BURST_ERR_LFSR_EN
      rnd_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cfg_mode_q   <= cfg_mode_d;
      cfg_start_q  <= cfg_start_d;
      cfg_len_q    <= cfg_len_d;
      cfg_step_q   <= cfg_step_d;
      cfg_period_q <= cfg_period_d;
      word_cnt_q   <= word_cnt_d;
      cur_start_q  <= cur_start_d;
      data_q       <= data_d;
      mask_q       <= mask_d;
      inj_q        <= inj_d;
      snap_mode_q  <= snap_mode_d;
      snap_start_q <= snap_start_d;
      snap_len_q   <= snap_len_d;
      inj_count_q  <= inj_count_d;
`ifdef BURST_ERR_LFSR_EN
      rnd_cnt_q    <= rnd_cnt_d;
`endif
    end
  end

endmodule
